// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO: default data width, depth and
// the pointer width derived from that depth.
package fifo_pkg;

  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Register-array storage for the FIFO: one clocked write port and one
// read port addressed by the read pointer, no reset on the contents.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge wclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The word under the read pointer is captured by the output register in the top.
  assign rd_data = mem[raddr];

endmodule : fifo_mem

// File: rtl/fifo_top.sv
// Single-clock FIFO with occupancy counter, glitch-free full/empty flags
// and a registered read-data output qualified by rvalid.
module fifo_top
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [DATA_W-1:0] wdata,
  input  logic              winc,
  input  logic              rinc,
  output logic              wfull,
  output logic              rempty,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic              wr_en_p0;
  logic              rd_en_p0;
  logic [DATA_W-1:0] mem_q_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              vld_p1;

  // Flags come straight from the registered count, so they never glitch.
  assign wfull  = (count == FULL_CNT);
  assign rempty = (count == '0);

  assign wr_en_p0 = winc && !wfull;
  assign rd_en_p0 = rinc && !rempty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .wclk    (wclk),
    .we      (wr_en_p0),
    .waddr   (wptr),
    .wdata   (wdata),
    .raddr   (rptr),
    .rd_data (mem_q_p0)
  );

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en_p0) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (rd_en_p0) begin
        rptr <= rptr + ADDR_W'(1);
      end
      if (wr_en_p0 && !rd_en_p0) begin
        count <= count + (ADDR_W + 1)'(1);
      end else if (rd_en_p0 && !wr_en_p0) begin
        count <= count - (ADDR_W + 1)'(1);
      end
    end
  end

  // p0 -> p1: accepted read lands in the output register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      rdata_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= rd_en_p0;
      if (rd_en_p0) begin
        rdata_p1 <= mem_q_p0;
      end
    end
  end

  assign rdata  = rdata_p1;
  assign rvalid = vld_p1;

endmodule : fifo_top

// File: tb/tb_fifo_top.sv
// Randomized self-checking bench for fifo_top against a queue-based
// reference model of the FIFO's observable behaviour.
module tb_fifo_top;
  import fifo_pkg::*;

  localparam int DW = FIFO_DATA_W;
  localparam int DP = FIFO_DEPTH;

  logic          wclk;
  logic          wrst_n;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          rinc;
  logic          wfull;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rvalid;

  int n_checks;
  int n_errors;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] exp_rdata;
  logic          exp_rvalid;

  fifo_top dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .wfull  (wfull),
    .rempty (rempty),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_rdata  = '0;
    exp_rvalid = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rempty"}, 32'(rempty), 32'(model_q.size() == 0));
    chk({tag, ".wfull"},  32'(wfull),  32'(model_q.size() == DP));
    chk({tag, ".rvalid"}, 32'(rvalid), 32'(exp_rvalid));
    chk({tag, ".rdata"},  32'(rdata),  32'(exp_rdata));
  endtask

  // Drive one cycle at the falling edge, predict, then check at the next falling edge.
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input string tag);
    bit wacc;
    bit racc;
    winc  = w;
    rinc  = r;
    wdata = d;
    wacc = w && (model_q.size() < DP);
    racc = r && (model_q.size() > 0);
    if (racc) begin
      exp_rdata  = model_q.pop_front();
      exp_rvalid = 1'b1;
    end else begin
      exp_rvalid = 1'b0;
    end
    if (wacc) model_q.push_back(d);
    @(posedge wclk);
    @(negedge wclk);
    check_outputs(tag);
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n = 1'b0;
    winc   = 1'b1;
    rinc   = 1'b1;
    wdata  = 16'hBEEF;
    model_reset();
    repeat (3) @(negedge wclk);
    check_outputs("reset");
    wrst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    wrst_n = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = '0;
    model_reset();

    do_reset();

    // Fill, overfill, drain, underflow
    for (int i = 0; i < DP; i++) cyc(1'b1, 1'b0, DW'(i), "fill");
    cyc(1'b1, 1'b0, 16'hDEAD, "overfill");
    for (int i = 0; i < DP; i++) cyc(1'b0, 1'b1, 16'h0, "drain");
    cyc(1'b0, 1'b1, 16'h0, "underflow");
    cyc(1'b1, 1'b1, 16'h00AA, "wr_rd_empty");

    // Fill again then simultaneous write+read while full
    for (int i = 0; i < DP; i++) cyc(1'b1, 1'b0, DW'(16'h0100 + i), "refill");
    cyc(1'b1, 1'b1, 16'hDEAD, "wr_rd_full");
    cyc(1'b1, 1'b1, 16'h0200, "wr_rd_almost");

    // Streaming from reset release
    do_reset();
    for (int i = 0; i < 24; i++) cyc(1'b1, 1'b1, DW'(i), "stream");

    // Randomized phases with varying write/read bias to sweep full, empty and wrap
    for (int p = 0; p < 6; p++) begin
      int pw;
      int pr;
      pw = (p % 3 == 0) ? 80 : ((p % 3 == 1) ? 20 : 50);
      pr = 100 - pw;
      for (int i = 0; i < 300; i++) begin
        cyc(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
            DW'($urandom), "random");
      end
    end

    // Mid-run reset with five words stored and rvalid high
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, DW'(16'h0A00 + i), "pre_rst");
    cyc(1'b0, 1'b1, 16'h0, "pre_rst_rd");
    #2;
    wrst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(negedge wclk);
    winc = 1'b0;
    rinc = 1'b0;
    wrst_n = 1'b1;
    cyc(1'b1, 1'b0, 16'h1234, "post_rst_wr");
    cyc(1'b0, 1'b1, 16'h0, "post_rst_rd");
    cyc(1'b0, 1'b0, 16'h0, "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fifo_top
